condiciona_entradas: RTL and testbench

- Input-conditioning stage directly upstream of the experiment top level (the iniciar / chaves consumer).
- Takes the raw push-button and the 4 slide switches from the board pins, synchronizes them to clock, debounces them, and produces:
  - a clean single-cycle iniciar pulse;
  - stable switch values for the datapath.
- Also exposes debug signals that the top level can route to hexa7seg displays.

---
 rtl/condiciona_entradas_pkg.sv | 22 ++
 rtl/condiciona_entradas_if.sv | 32 +++
 rtl/condiciona_entradas_debounce_canal.sv | 52 +++++
 rtl/condiciona_entradas.sv | 68 ++++++
 tb/tb_condiciona_entradas.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/condiciona_entradas_pkg.sv
// ============================================================================
// condiciona_entradas_pkg: shared constants and types for input conditioning
// Rev 1.0
// ============================================================================
`default_nettype none

package condiciona_entradas_pkg;

  localparam int DEBOUNCE_CICLOS_PADRAO = 50000;  // 1 ms at 50 MHz
  localparam int DEBOUNCE_SIM           = 4;      // short window for simulation
  localparam int N_CHAVES_PADRAO        = 4;

  typedef enum logic {
    NIVEL_0 = 1'b0,
    NIVEL_1 = 1'b1
  } nivel_t;

  typedef logic [3:0] pressoes_t;

endpackage

`default_nettype wire

// File: rtl/condiciona_entradas_if.sv
// ============================================================================
// condiciona_entradas_if: raw board inputs in, conditioned signals out
// Rev 1.0
// ============================================================================
`default_nettype none

interface condiciona_entradas_if
  import condiciona_entradas_pkg::*;
#(
  parameter int N_CHAVES = N_CHAVES_PADRAO
);

  logic                botao_iniciar;
  logic [N_CHAVES-1:0] chaves_in;
  logic                iniciar;
  logic [N_CHAVES-1:0] chaves;
  logic                db_botao;
  pressoes_t           db_pressoes;

  modport master (
    output botao_iniciar, chaves_in,
    input  iniciar, chaves, db_botao, db_pressoes
  );

  modport slave (
    input  botao_iniciar, chaves_in,
    output iniciar, chaves, db_botao, db_pressoes
  );

endinterface

`default_nettype wire

// File: rtl/condiciona_entradas_debounce_canal.sv
// ============================================================================
// debounce_canal: 2-flop synchronizer followed by a counting debounce FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_canal
  import condiciona_entradas_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic entrada,
  output logic      estavel
);

  localparam int                CW       = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0]     CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

  logic          s1;
  logic          s2;
  nivel_t        estado;
  logic [CW-1:0] cont;

  // Any sample agreeing with the stable level restarts the count, so only an
  // uninterrupted run of DEBOUNCE_CICLOS differing samples is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      estado <= NIVEL_0;
      cont   <= '0;
    end else begin
      s1 <= entrada;
      s2 <= s1;
      if (s2 == logic'(estado)) begin
        cont <= '0;
      end else if (cont == CONT_MAX) begin
        estado <= s2 ? NIVEL_1 : NIVEL_0;
        cont   <= '0;
      end else begin
        cont <= cont + 1'b1;
      end
    end
  end

  assign estavel = (estado == NIVEL_1);

endmodule

`default_nettype wire

// File: rtl/condiciona_entradas.sv
// ============================================================================
// condiciona_entradas: debounced button pulse, switches and press counter
// Rev 1.0
// ============================================================================
`default_nettype none

module condiciona_entradas
  import condiciona_entradas_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int N_CHAVES        = N_CHAVES_PADRAO
) (
  input wire logic              clock,
  input wire logic              reset,
  condiciona_entradas_if.slave  bus
);

  logic                estavel_botao;
  logic                botao_d;
  logic [N_CHAVES-1:0] estavel_chaves;
  pressoes_t           pressoes;
  logic                pulso;

  debounce_canal #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_botao (
    .clock   (clock),
    .reset   (reset),
    .entrada (bus.botao_iniciar),
    .estavel (estavel_botao)
  );

  generate
    for (genvar i = 0; i < N_CHAVES; i++) begin : g_chaves
      debounce_canal #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
      ) u_chave (
        .clock   (clock),
        .reset   (reset),
        .entrada (bus.chaves_in[i]),
        .estavel (estavel_chaves[i])
      );
    end
  endgenerate

  // Rising edge of the debounced level only; a held button gives one pulse.
  assign pulso = estavel_botao & ~botao_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      botao_d  <= 1'b0;
      pressoes <= '0;
    end else begin
      botao_d <= estavel_botao;
      if (pulso) begin
        pressoes <= pressoes + 1'b1;
      end
    end
  end

  assign bus.iniciar     = pulso;
  assign bus.chaves      = estavel_chaves;
  assign bus.db_botao    = estavel_botao;
  assign bus.db_pressoes = pressoes;

endmodule

`default_nettype wire

// File: tb/tb_condiciona_entradas.sv
// ============================================================================
// tb_condiciona_entradas: directed stimulus, window-based reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_condiciona_entradas;
  import condiciona_entradas_pkg::*;

  localparam int D = DEBOUNCE_SIM;
  localparam int N = 4;

  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   pulse_cnt = 0;

  condiciona_entradas_if #(.N_CHAVES(N)) bus ();

  condiciona_entradas #(
    .DEBOUNCE_CICLOS(D),
    .N_CHAVES       (N)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: per channel, the pin samples of the last D+1 edges. A level is
  // accepted once the D samples that have crossed the 2-stage delay all differ.
  bit [D:0] hist [N+1];
  bit       m_est [N+1];
  bit       m_pulse;
  int       m_press;

  function automatic bit muda(bit [D:0] h, bit est);
    return h[D:1] == {D{~est}};
  endfunction

  function automatic logic [N-1:0] model_chaves();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_est[i+1];
    return r;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c <= N; c++) begin
        hist[c]  <= '0;
        m_est[c] <= 1'b0;
      end
      m_pulse <= 1'b0;
      m_press <= 0;
    end else begin
      hist[0] <= {hist[0][D-1:0], bus.botao_iniciar};
      for (int i = 0; i < N; i++) hist[i+1] <= {hist[i+1][D-1:0], bus.chaves_in[i]};
      for (int c = 0; c <= N; c++) begin
        if (muda(hist[c], m_est[c])) m_est[c] <= ~m_est[c];
      end
      m_pulse <= muda(hist[0], m_est[0]) && !m_est[0];
      if (m_pulse) m_press <= m_press + 1;
    end
  end

  always @(posedge clock) begin
    if (bus.iniciar) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("model_iniciar",     32'(bus.iniciar),     32'(m_pulse));
    check("model_db_botao",    32'(bus.db_botao),    32'(m_est[0]));
    check("model_chaves",      32'(bus.chaves),      32'(model_chaves()));
    check("model_db_pressoes", 32'(bus.db_pressoes), 32'(m_press % 16));
  end

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_iniciar"},  32'(bus.iniciar),     32'd0);
    check({tag, "_chaves"},   32'(bus.chaves),      32'd0);
    check({tag, "_db_botao"}, 32'(bus.db_botao),    32'd0);
    check({tag, "_pressoes"}, 32'(bus.db_pressoes), 32'd0);
  endtask

  initial begin
    logic [5:0] pat;
    reset = 1'b1;
    bus.botao_iniciar = 1'b0;
    bus.chaves_in     = '0;
    ciclos(3);
    reset = 1'b0;
    check_zero("rst");
    ciclos(20);
    check("idle_pulses", 32'(pulse_cnt), 32'd0);

    // clean press: level appears after 6 edges, pulse only in that cycle
    bus.botao_iniciar = 1'b1;
    ciclos(5);
    check("press_db_pre", 32'(bus.db_botao), 32'd0);
    ciclos(1);
    check("press_db",      32'(bus.db_botao), 32'd1);
    check("press_iniciar", 32'(bus.iniciar),  32'd1);
    ciclos(1);
    check("press_ini_off",  32'(bus.iniciar),     32'd0);
    check("press_pressoes", 32'(bus.db_pressoes), 32'd1);
    ciclos(50);
    check("press_held_pulses", 32'(pulse_cnt), 32'd1);
    bus.botao_iniciar = 1'b0;
    ciclos(10);

    // bounce 1,0,1,1,0,1 then steady high
    pat = 6'b101101;
    for (int i = 5; i >= 0; i--) begin
      bus.botao_iniciar = pat[i];
      ciclos(1);
    end
    ciclos(4);
    check("bounce_ini_early", 32'(bus.iniciar), 32'd0);
    ciclos(1);
    check("bounce_iniciar", 32'(bus.iniciar), 32'd1);
    ciclos(10);
    bus.botao_iniciar = 1'b0;
    ciclos(10);
    check("bounce_pulses", 32'(pulse_cnt), 32'd2);

    // isolated 3-cycle high glitch
    bus.botao_iniciar = 1'b1;
    ciclos(3);
    bus.botao_iniciar = 1'b0;
    ciclos(10);
    check("glitch_pulses", 32'(pulse_cnt), 32'd2);
    check("glitch_db",     32'(bus.db_botao), 32'd0);

    // switches
    bus.chaves_in = 4'b1010;
    ciclos(5);
    check("chaves_pre", 32'(bus.chaves), 32'h0);
    ciclos(1);
    check("chaves_new", 32'(bus.chaves), 32'ha);
    bus.chaves_in = 4'b0101;
    ciclos(3);
    bus.chaves_in = 4'b1010;
    ciclos(10);
    check("chaves_glitch", 32'(bus.chaves), 32'ha);

    // 17 presses from a fresh counter, last one left held
    bus.chaves_in = '0;
    reset = 1'b1;
    ciclos(1);
    reset = 1'b0;
    check("wrap_start", 32'(bus.db_pressoes), 32'd0);
    for (int p = 0; p < 17; p++) begin
      bus.botao_iniciar = 1'b1;
      ciclos(8);
      if (p < 16) begin
        bus.botao_iniciar = 1'b0;
        ciclos(8);
      end
    end
    check("wrap_pressoes", 32'(bus.db_pressoes), 32'd1);
    check("wrap_db_held",  32'(bus.db_botao),    32'd1);

    // asynchronous reset between edges
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check_zero("async");
    bus.botao_iniciar = 1'b0;
    ciclos(1);
    reset = 1'b0;
    ciclos(3);

    // reset in the middle of a debounce count, pin still high afterwards
    bus.botao_iniciar = 1'b1;
    ciclos(4);
    reset = 1'b1;
    ciclos(1);
    reset = 1'b0;
    check("midrst_db", 32'(bus.db_botao), 32'd0);
    for (int i = 0; i < 5; i++) begin
      ciclos(1);
      check("midrst_early", 32'(bus.iniciar), 32'd0);
    end
    ciclos(1);
    check("midrst_iniciar", 32'(bus.iniciar), 32'd1);
    ciclos(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
